// File: rtl/lock_pkg.sv
// Shared types and display codes for the combination-lock entry controller.
// The display codes are also consumed by the seven-segment message/buzzer driver.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        OPEN,
        ERR,
        LOCKOUT
    } lock_state_t;

    localparam logic [2:0] ST_ERR  = 3'b001;
    localparam logic [2:0] ST_ON   = 3'b010;
    localparam logic [2:0] ST_OFF  = 3'b011;
    localparam logic [2:0] ST_OPEN = 3'b100;

    // Index of a one-hot press vector; the result is don't-care for other vectors.
    function automatic logic [1:0] btn_index(input logic [3:0] p);
        return {p[3] | p[2], p[3] | p[1]};
    endfunction

    function automatic logic [2:0] disp_code(input lock_state_t s);
        case (s)
            ENTRY:        return ST_ON;
            OPEN:         return ST_OPEN;
            ERR, LOCKOUT: return ST_ERR;
            default:      return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and rising-edge
// detect producing a single-cycle press pulse on the accepted value.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int            CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          r_s1, r_s2;
    logic          r_stable, r_stable_d, r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            // Any bounce back to the accepted level restarts the stability window.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/lock_entry_ctrl.sv
// Combination-lock entry controller: debounced buttons feed a 4-digit code FSM
// that drives the display code, the buzzer trigger and the unlock relay.
module lock_entry_ctrl
    import lock_pkg::*;
#(
    parameter int         DEBOUNCE_CYC      = 1_000_000,
    parameter int         ENTRY_TIMEOUT_CYC = 500_000_000,
    parameter int         OPEN_CYC          = 250_000_000,
    parameter int         ERR_CYC           = 100_000_000,
    parameter int         LOCKOUT_CYC       = 1_500_000_000,
    parameter int         MAX_TRIES         = 3,
    parameter logic [7:0] SECRET            = 8'b00_01_10_11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [2:0] state,
    output logic       buzz,
    output logic       unlock
);
    localparam int TW  = 31;
    localparam int FCW = $clog2(MAX_TRIES + 1);
    localparam int BZW = (ERR_CYC > 1) ? $clog2(ERR_CYC) : 1;

    localparam logic [TW-1:0]  T_ENTRY = TW'(ENTRY_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  T_OPEN  = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0]  T_ERR   = TW'(ERR_CYC - 1);
    localparam logic [TW-1:0]  T_LOCK  = TW'(LOCKOUT_CYC - 1);
    localparam logic [BZW-1:0] BZ_MAX  = BZW'(ERR_CYC - 1);
    localparam logic [FCW-1:0] F_MAX   = FCW'(MAX_TRIES);

    logic [3:0]     w_press;
    logic           w_ev, w_valid, w_match, w_buzz, w_tmr_clr;
    logic [1:0]     w_dig;
    logic [FCW-1:0] w_fail_inc, w_fail_nxt;
    lock_state_t    r_state, w_next;

    logic [TW-1:0]  r_tmr;
    logic [BZW-1:0] r_bz;
    logic [FCW-1:0] r_fail;
    logic [5:0]     r_code;
    logic [1:0]     r_idx;
    logic           r_bad;
    logic [2:0]     r_disp;
    logic           r_buzz, r_unlock;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (btn[gi]),
            .o_press(w_press[gi])
        );
    end

    assign w_ev       = |w_press;
    assign w_valid    = $onehot(w_press);
    assign w_dig      = btn_index(w_press);
    assign w_fail_inc = r_fail + 1'b1;
    // The 4th digit is compared as it arrives, so the buffer holds only three.
    assign w_match    = w_valid && !r_bad && ({r_code, w_dig} == SECRET);

    always_comb begin
        w_next     = r_state;
        w_buzz     = 1'b0;
        w_tmr_clr  = 1'b0;
        w_fail_nxt = r_fail;
        case (r_state)
            IDLE: begin
                if (w_ev) w_next = ENTRY;
            end
            ENTRY: begin
                if (w_ev) begin
                    w_tmr_clr = 1'b1;
                    if (r_idx == 2'd3) begin
                        if (w_match) begin
                            w_next     = OPEN;
                            w_fail_nxt = '0;
                        end else begin
                            w_buzz     = 1'b1;
                            w_fail_nxt = w_fail_inc;
                            w_next     = (w_fail_inc == F_MAX) ? LOCKOUT : ERR;
                        end
                    end
                end else if (r_tmr == T_ENTRY) begin
                    w_next = IDLE;
                end
            end
            OPEN: begin
                if (r_tmr == T_OPEN) w_next = IDLE;
            end
            ERR: begin
                if (r_tmr == T_ERR) w_next = IDLE;
            end
            LOCKOUT: begin
                if (r_tmr == T_LOCK) begin
                    w_next     = IDLE;
                    w_fail_nxt = '0;
                end else if (r_bz == BZ_MAX) begin
                    w_buzz = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            r_bz     <= '0;
            r_fail   <= '0;
            r_code   <= '0;
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_disp   <= ST_OFF;
            r_buzz   <= 1'b0;
            r_unlock <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fail  <= w_fail_nxt;
            if (w_next != r_state || w_tmr_clr || r_state == IDLE) r_tmr <= '0;
            else                                                 r_tmr <= r_tmr + 1'b1;
            // Buzz cadence within LOCKOUT, phase-aligned to state entry.
            if (w_next != r_state || r_bz == BZ_MAX) r_bz <= '0;
            else                                     r_bz <= r_bz + 1'b1;
            if (w_ev && r_state == IDLE) begin
                r_code <= {4'b0, w_dig};
                r_idx  <= 2'd1;
                r_bad  <= !w_valid;
            end else if (w_ev && r_state == ENTRY) begin
                r_code <= {r_code[3:0], w_dig};
                r_idx  <= r_idx + 1'b1;
                r_bad  <= r_bad | !w_valid;
            end
            r_disp   <= disp_code(w_next);
            r_buzz   <= w_buzz;
            r_unlock <= (w_next == OPEN);
        end
    end

    assign state  = r_disp;
    assign buzz   = r_buzz;
    assign unlock = r_unlock;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Bench for lock_entry_ctrl: code-vector table, hand-written timing corners,
// then a randomized run compared against an event-level model every cycle.
`timescale 1ns/1ps
module tb_lock_entry_ctrl;
    localparam int DEB = 4, ETO = 50, OPC = 20, ERC = 10, LKC = 40, MT = 3;
    localparam logic [7:0] SECRET = 8'b00_01_10_11;
    localparam int LAT = 2 + DEB + 1;  // raw edge to press pulse; FSM reacts one edge later
    localparam int MI = 0, ME = 1, MO = 2, MR = 3, ML = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [2:0] state;
    logic       buzz, unlock;
    int         errors = 0, checks = 0, nbuzz = 0;

    lock_entry_ctrl #(
        .DEBOUNCE_CYC(DEB), .ENTRY_TIMEOUT_CYC(ETO), .OPEN_CYC(OPC),
        .ERR_CYC(ERC), .LOCKOUT_CYC(LKC), .MAX_TRIES(MT), .SECRET(SECRET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .state(state), .buzz(buzz), .unlock(unlock)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (buzz) nbuzz++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic [15:0] m;     // four press masks, first press in [15:12]
        logic [2:0]  st;
        logic        ul;
        logic        bz;
        int          dwell;
    } vec_t;
    vec_t vt[9];

    function automatic vec_t mk(input string nm, input logic [15:0] m, input logic [2:0] st,
                                input logic ul, input logic bz, input int dwell);
        vec_t v;
        v.nm = nm; v.m = m; v.st = st; v.ul = ul; v.bz = bz; v.dwell = dwell;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: returns just after the edge at which the FSM has acted on it.
    task automatic hit(input logic [3:0] m);
        btn = m;
        tk(LAT + 1);
        btn = 4'b0;
    endtask

    task automatic enter4(input logic [15:0] m);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tk(8);
            hit(m[15-4*k -: 4]);
        end
    endtask

    function automatic int sdig(input int k);
        return int'((SECRET >> (6 - 2 * k)) & 8'd3);
    endfunction

    function automatic int midx(input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) return k;
        return -1;
    endfunction

    function automatic logic [2:0] mcode(input int md);
        case (md)
            ME:      return 3'b010;
            MO:      return 3'b100;
            MR, ML:  return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [3:0] pick(input int n);
        int         r;
        logic [3:0] one, two;
        one = 4'b0001;
        two = 4'b0011;
        r = $urandom_range(0, 9);
        if (r < 4) return one << sdig(n % 4);
        if (r < 9) return one << $urandom_range(0, 3);
        return two << $urandom_range(0, 2);
    endfunction

    // event-level model state
    int         mmode, mfail, mlast, mt0, hold_left, gap_left, npress;
    logic [3:0] mdig[$];
    logic [3:0] dl[LAT];
    logic [3:0] prev, rise, ev;
    logic       mbz, ok;

    initial begin
        vt[0] = mk("ok_first",   16'h1248, 3'b100, 1'b1, 1'b0, OPC);
        vt[1] = mk("wrong_3333", 16'h8888, 3'b001, 1'b0, 1'b1, ERC);
        vt[2] = mk("wrong_0122", 16'h1244, 3'b001, 1'b0, 1'b1, ERC);
        vt[3] = mk("ok_clears",  16'h1248, 3'b100, 1'b1, 1'b0, OPC);
        vt[4] = mk("multi_d0",   16'h3248, 3'b001, 1'b0, 1'b1, ERC);
        vt[5] = mk("multi_d3",   16'h124C, 3'b001, 1'b0, 1'b1, ERC);
        vt[6] = mk("third_lock", 16'h2148, 3'b001, 1'b0, 1'b1, LKC);
        vt[7] = mk("after_lock", 16'h8421, 3'b001, 1'b0, 1'b1, ERC);
        vt[8] = mk("ok_again",   16'h1248, 3'b100, 1'b1, 1'b0, OPC);

        // reset state, then a quiet idle period
        #23;
        chk("rst_state", state, 3'b011);
        chk("rst_buzz", buzz, 1'b0);
        chk("rst_unlock", unlock, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tk(10);
            chk("idle_quiet", {state, unlock, buzz}, {3'b011, 1'b0, 1'b0});
        end

        // code table; fail count carries from one row to the next
        foreach (vt[i]) begin
            enter4(vt[i].m);
            chk({vt[i].nm, "_st"}, state, vt[i].st);
            chk({vt[i].nm, "_ul"}, unlock, vt[i].ul);
            chk({vt[i].nm, "_bz"}, buzz, vt[i].bz);
            tk(vt[i].dwell - 1);
            chk({vt[i].nm, "_hold"}, {state, unlock}, {vt[i].st, vt[i].ul});
            tk(1);
            chk({vt[i].nm, "_back"}, {state, unlock}, {3'b011, 1'b0});
        end

        // lockout buzz cadence, then a correct code on the first try
        for (int t = 0; t < 2; t++) begin
            enter4(16'h8888);
            tk(ERC);
            chk("pre_lock_idle", state, 3'b011);
        end
        enter4(16'h8888);
        chk("lk_entry", {state, buzz}, {3'b001, 1'b1});
        for (int k = 1; k < LKC; k++) begin
            tk(1);
            chk("lk_cadence", {state, buzz}, {3'b001, (k % ERC) == 0});
        end
        tk(1);
        chk("lk_exit", {state, buzz}, {3'b011, 1'b0});
        enter4(16'h1248);
        chk("lk_then_ok", {state, unlock}, {3'b100, 1'b1});
        tk(OPC);

        // entry timeout: silent return to idle, fresh code afterwards
        hit(4'b0001);
        tk(8);
        hit(4'b0010);
        chk("to_entry", state, 3'b010);
        begin
            int b0;
            b0 = nbuzz;
            tk(ETO - 1);
            chk("to_hold", state, 3'b010);
            tk(1);
            chk("to_idle", state, 3'b011);
            tk(3);
            chk("to_nobuzz", nbuzz, b0);
        end
        enter4(16'h1248);
        chk("to_fresh", state, 3'b100);
        tk(OPC);

        // a press landing on the timeout edge wins
        hit(4'b0001);
        tk(ETO - LAT - 1);
        hit(4'b0010);
        chk("to_coincide", state, 3'b010);
        tk(8); hit(4'b0100);
        tk(8); hit(4'b1000);
        chk("to_coincide_ok", state, 3'b100);
        tk(OPC);

        // bouncing btn[0], then a long hold: one event in total
        for (int k = 0; k < 3; k++) begin
            btn = 4'b0001; tk(2);
            btn = 4'b0000; tk(2);
        end
        tk(4);
        chk("bounce_quiet", state, 3'b011);
        btn = 4'b0001;
        tk(LAT + 1);
        chk("bounce_one", state, 3'b010);
        tk(22);
        btn = 4'b0;
        tk(8); hit(4'b0010);
        tk(8); hit(4'b0100);
        tk(8); hit(4'b1000);
        chk("bounce_open", {state, unlock}, {3'b100, 1'b1});

        // asynchronous reset in the middle of OPEN
        tk(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_unlock", unlock, 1'b0);
        chk("arst_state", state, 3'b011);
        tk(2);
        rst_n = 1'b1;

        // randomized run against the event-level model
        mmode = MI; mfail = 0; mlast = 0; mt0 = 0;
        hold_left = 0; gap_left = 10; npress = 0;
        prev = 4'b0; btn = 4'b0;
        mdig.delete();
        for (int k = 0; k < LAT; k++) dl[k] = 4'b0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    btn = 4'b0;
                    gap_left = ($urandom_range(0, 7) == 0) ? $urandom_range(45, 70)
                                                           : $urandom_range(6, 14);
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else begin
                btn = pick(npress);
                npress++;
                hold_left = $urandom_range(6, 12);
            end
            rise = btn & ~prev;
            prev = btn;
            @(posedge clk);
            ev = dl[LAT-1];
            for (int k = LAT - 1; k > 0; k--) dl[k] = dl[k-1];
            dl[0] = rise;
            mbz = 1'b0;
            case (mmode)
                MI: if (ev != 0) begin
                    mdig.delete();
                    mdig.push_back(ev);
                    mlast = c;
                    mmode = ME;
                end
                ME: if (ev != 0) begin
                    mdig.push_back(ev);
                    mlast = c;
                    if (mdig.size() == 4) begin
                        ok = 1'b1;
                        for (int k = 0; k < 4; k++)
                            if ($countones(mdig[k]) != 1 || midx(mdig[k]) != sdig(k)) ok = 1'b0;
                        mt0 = c;
                        if (ok) begin
                            mmode = MO;
                            mfail = 0;
                        end else begin
                            mfail++;
                            mbz = 1'b1;
                            mmode = (mfail == MT) ? ML : MR;
                        end
                    end
                end else if (c - mlast == ETO) begin
                    mmode = MI;
                end
                MO: if (c - mt0 == OPC) mmode = MI;
                MR: if (c - mt0 == ERC) mmode = MI;
                ML: if (c - mt0 == LKC) begin
                    mmode = MI;
                    mfail = 0;
                end else if ((c - mt0) % ERC == 0) begin
                    mbz = 1'b1;
                end
                default: mmode = MI;
            endcase
            #1;
            chk("rand", {state, unlock, buzz}, {mcode(mmode), mmode == MO, mbz});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
